// File: rtl/dp_ram_pkg.sv
// Shared types and constants for the dual-port RAM FIFO controller.
package dp_ram_pkg;

  localparam int OBUF_DEPTH = 2;

  typedef enum logic [1:0] {
    OBUF_EMPTY,
    OBUF_ONE,
    OBUF_TWO
  } obuf_state_t;

endpackage

// File: rtl/dp_ram_fifo_obuf.sv
// Two-entry registered output buffer that absorbs the RAM read latency and
// presents the oldest word on a valid/ready interface.
module dp_ram_fifo_obuf
  import dp_ram_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  CLKA,
  input  logic                  rst_n,
  input  logic                  capture_i,
  input  logic [DATA_WIDTH-1:0] capture_data_i,
  input  logic                  rd_ready_i,
  output logic                  rd_valid_o,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic [1:0]            buf_cnt_o,
  output logic                  pop_o
);

  obuf_state_t           state_q, state_d;
  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] tail_q, tail_d;

  // Head always holds the oldest word; tail is only meaningful in OBUF_TWO.
  always_comb begin
    state_d   = state_q;
    head_d    = head_q;
    tail_d    = tail_q;
    pop_o     = (state_q != OBUF_EMPTY) & rd_ready_i;
    buf_cnt_o = 2'd0;
    case (state_q)
      OBUF_EMPTY: begin
        if (capture_i) begin
          head_d  = capture_data_i;
          state_d = OBUF_ONE;
        end
      end
      OBUF_ONE: begin
        buf_cnt_o = 2'd1;
        if (capture_i && !pop_o) begin
          tail_d  = capture_data_i;
          state_d = OBUF_TWO;
        end else if (!capture_i && pop_o) begin
          state_d = OBUF_EMPTY;
        end else if (capture_i && pop_o) begin
          head_d = capture_data_i;
        end
      end
      OBUF_TWO: begin
        buf_cnt_o = 2'd2;
        if (pop_o) begin
          head_d = tail_q;
          if (capture_i) begin
            tail_d = capture_data_i;
          end else begin
            state_d = OBUF_ONE;
          end
        end
      end
      default: state_d = OBUF_EMPTY;
    endcase
  end

  always_ff @(posedge CLKA) begin
    if (!rst_n) begin
      state_q <= OBUF_EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  assign rd_valid_o = (state_q != OBUF_EMPTY);
  assign rd_data_o  = head_q;

endmodule

// File: rtl/dp_ram_fifo_ctrl.sv
// FIFO controller for a dual-port RAM macro (read port A, write port B) with
// a credit-limited prefetch into a two-entry output buffer.
module dp_ram_fifo_ctrl
  import dp_ram_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  CLKA,
  input  logic                  rst_n,
  input  logic                  wr_valid_i,
  output logic                  wr_ready_o,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  output logic                  rd_valid_o,
  input  logic                  rd_ready_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic [ADDR_WIDTH+1:0] count_o,
  output logic                  mem_cea_o,
  output logic [ADDR_WIDTH-1:0] mem_aa_o,
  output logic                  mem_ceb_o,
  output logic [ADDR_WIDTH-1:0] mem_ab_o,
  output logic [DATA_WIDTH-1:0] mem_db_o,
  output logic [DATA_WIDTH-1:0] mem_bwb_o,
  input  logic [DATA_WIDTH-1:0] mem_qa_i
);

  localparam int PW    = ADDR_WIDTH + 1;
  localparam int CW    = ADDR_WIDTH + 2;
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] ram_cnt;
  logic          pend_q, pend_d;
  logic [CW-1:0] count_q, count_d;
  logic          push;
  logic          issue;
  logic          pop;
  logic [1:0]    buf_cnt;
  logic [2:0]    inflight;
  logic [2:0]    credit_lim;

  // A read is only issued while the buffer plus the in-flight word still has
  // room after this cycle's pop, so a capture can never hit a full buffer.
  always_comb begin
    ram_cnt    = wr_ptr_q - rd_ptr_q;
    wr_ready_o = (ram_cnt != PW'(DEPTH));
    push       = wr_valid_i & wr_ready_o & rst_n;
    inflight   = {1'b0, buf_cnt} + {2'b00, pend_q};
    credit_lim = 3'(OBUF_DEPTH) + {2'b00, pop};
    issue      = (ram_cnt != '0) & (inflight < credit_lim) & rst_n;
    wr_ptr_d   = wr_ptr_q + PW'(push);
    rd_ptr_d   = rd_ptr_q + PW'(issue);
    pend_d     = issue;
    count_d    = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge CLKA) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      pend_q   <= 1'b0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      pend_q   <= pend_d;
      count_q  <= count_d;
    end
  end

  dp_ram_fifo_obuf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_obuf (
    .CLKA          (CLKA),
    .rst_n         (rst_n),
    .capture_i     (pend_q),
    .capture_data_i(mem_qa_i),
    .rd_ready_i    (rd_ready_i),
    .rd_valid_o    (rd_valid_o),
    .rd_data_o     (rd_data_o),
    .buf_cnt_o     (buf_cnt),
    .pop_o         (pop)
  );

  assign count_o   = count_q;
  assign mem_cea_o = issue;
  assign mem_aa_o  = rd_ptr_q[ADDR_WIDTH-1:0];
  assign mem_ceb_o = push;
  assign mem_ab_o  = wr_ptr_q[ADDR_WIDTH-1:0];
  assign mem_db_o  = wr_data_i;
  assign mem_bwb_o = '1;

endmodule

// File: tb/tb_dp_ram_fifo_ctrl.sv
// Scoreboard bench for dp_ram_fifo_ctrl with a behavioural dual-port RAM and
// a queue-based model of FIFO contents and capacity.
module tb_dp_ram_fifo_ctrl;

  localparam int AW    = 2;
  localparam int DW    = 32;
  localparam int DEPTH = 2 ** AW;
  localparam int CAP   = DEPTH + 2;

  logic          CLKA = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_valid_i = 1'b0;
  logic          wr_ready_o;
  logic [DW-1:0] wr_data_i = '0;
  logic          rd_valid_o;
  logic          rd_ready_i = 1'b0;
  logic [DW-1:0] rd_data_o;
  logic [AW+1:0] count_o;
  logic          mem_cea_o;
  logic [AW-1:0] mem_aa_o;
  logic          mem_ceb_o;
  logic [AW-1:0] mem_ab_o;
  logic [DW-1:0] mem_db_o;
  logic [DW-1:0] mem_bwb_o;
  logic [DW-1:0] mem_qa_i;

  logic [DW-1:0] ram [DEPTH];
  logic [DW-1:0] sb [$];
  int nVectors = 0;
  int nMiscompares = 0;

  always #5 CLKA = ~CLKA;

  dp_ram_fifo_ctrl #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW)
  ) dut (
    .CLKA      (CLKA),
    .rst_n     (rst_n),
    .wr_valid_i(wr_valid_i),
    .wr_ready_o(wr_ready_o),
    .wr_data_i (wr_data_i),
    .rd_valid_o(rd_valid_o),
    .rd_ready_i(rd_ready_i),
    .rd_data_o (rd_data_o),
    .count_o   (count_o),
    .mem_cea_o (mem_cea_o),
    .mem_aa_o  (mem_aa_o),
    .mem_ceb_o (mem_ceb_o),
    .mem_ab_o  (mem_ab_o),
    .mem_db_o  (mem_db_o),
    .mem_bwb_o (mem_bwb_o),
    .mem_qa_i  (mem_qa_i)
  );

  // RAM macro model: bit-masked write on port B, one-cycle registered read on port A.
  always @(posedge CLKA) begin
    if (mem_ceb_o) ram[mem_ab_o] <= (ram[mem_ab_o] & ~mem_bwb_o) | (mem_db_o & mem_bwb_o);
    if (mem_cea_o) mem_qa_i <= ram[mem_aa_o];
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    nVectors++;
    if (actual !== expected) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // One cycle of stimulus; accepted words enter the scoreboard in order.
  task automatic applyStimulus(input logic wv, input logic [DW-1:0] wd, input logic rr, output logic accepted);
    @(posedge CLKA);
    #1;
    wr_valid_i = wv;
    wr_data_i  = wd;
    rd_ready_i = rr;
    @(negedge CLKA);
    accepted = wv && wr_ready_o && rst_n;
    if (accepted) sb.push_back(wd);
  endtask

  task automatic doReset(input int cycles);
    @(posedge CLKA);
    #1;
    rst_n      = 1'b0;
    wr_valid_i = 1'b1;
    wr_data_i  = 32'hBAD0_BAD0;
    rd_ready_i = 1'b0;
    sb.delete();
    repeat (cycles) @(posedge CLKA);
    #1;
    rst_n      = 1'b1;
    wr_valid_i = 1'b0;
  endtask

  // Read-side monitor plus RAM port checks, sampled mid-cycle.
  initial begin
    logic [DW-1:0] expWord;
    forever begin
      @(negedge CLKA);
      if (!rst_n) begin
        checkOutput("ce_gated_in_reset", {62'd0, mem_cea_o, mem_ceb_o}, 64'd0);
      end else begin
        if (rd_valid_o && rd_ready_i) begin
          if (sb.size() == 0) begin
            nVectors++;
            nMiscompares++;
            $display("[TB] FAIL pop_without_word: got data 0x%0h, required no valid word at %0t", rd_data_o, $time);
          end else begin
            expWord = sb.pop_front();
            checkOutput("rd_data", rd_data_o, expWord);
          end
        end
        if (mem_ceb_o) checkOutput("bwb_all_ones", mem_bwb_o, {DW{1'b1}});
        if (mem_cea_o && mem_ceb_o) checkOutput("port_addr_distinct", mem_aa_o != mem_ab_o, 1);
      end
    end
  end

  // Occupancy and flow-control checks against the queue model.
  initial begin
    forever begin
      @(posedge CLKA);
      #2;
      if (rst_n) begin
        checkOutput("count_vs_model", count_o, sb.size());
        checkOutput("count_bound", count_o <= CAP, 1);
        if (sb.size() < DEPTH) checkOutput("wr_ready_with_room", wr_ready_o, 1);
        if (sb.size() == CAP) checkOutput("wr_ready_when_full", wr_ready_o, 0);
      end
    end
  end

  initial begin
    logic acc;
    int nAcc;
    int wBias;
    int rBias;

    // Reset state
    doReset(2);
    @(negedge CLKA);
    checkOutput("reset_rd_valid", rd_valid_o, 0);
    checkOutput("reset_wr_ready", wr_ready_o, 1);
    checkOutput("reset_count", count_o, 0);
    checkOutput("reset_ce", {mem_cea_o, mem_ceb_o}, 0);
    checkOutput("reset_rd_data", rd_data_o, 0);

    // Single-word latency
    applyStimulus(1'b1, 32'hDEAD_BEEF, 1'b1, acc);
    checkOutput("lat_push_accepted", acc, 1);
    applyStimulus(1'b0, '0, 1'b1, acc);
    checkOutput("lat_count_n1", count_o, 1);
    checkOutput("lat_issue_n1", mem_cea_o, 1);
    applyStimulus(1'b0, '0, 1'b1, acc);
    checkOutput("lat_rd_valid_n2", rd_valid_o, 0);
    applyStimulus(1'b0, '0, 1'b1, acc);
    checkOutput("lat_rd_valid_n3", rd_valid_o, 1);
    checkOutput("lat_rd_data_n3", rd_data_o, 32'hDEAD_BEEF);
    applyStimulus(1'b0, '0, 1'b1, acc);
    checkOutput("lat_count_n4", count_o, 0);
    checkOutput("lat_rd_valid_n4", rd_valid_o, 0);

    // Fill to capacity with the consumer stalled, then drain in order
    nAcc = 0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, DW'(i), 1'b0, acc);
      nAcc += int'(acc);
    end
    checkOutput("fill_accepted", nAcc, CAP);
    checkOutput("fill_wr_ready", wr_ready_o, 0);
    checkOutput("fill_count", count_o, CAP);
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, '0, 1'b1, acc);
    checkOutput("drain_count", count_o, 0);
    checkOutput("drain_model_empty", sb.size(), 0);

    // Streaming: push and pop every cycle
    for (int k = 0; k < 26; k++) begin
      applyStimulus(k < 20, DW'(100 + k), 1'b1, acc);
      if (k < 20) checkOutput("stream_accept", acc, 1);
      if (k >= 3 && k < 23) checkOutput("stream_rd_valid", rd_valid_o, 1);
      if (k == 23) checkOutput("stream_end_rd_valid", rd_valid_o, 0);
    end
    checkOutput("stream_model_empty", sb.size(), 0);

    // Randomized traffic with shifting producer/consumer rates
    for (int cyc = 0; cyc < 10000; cyc++) begin
      wBias = 1 + (cyc / 1000) % 3;
      rBias = 3 - (cyc / 700) % 3;
      applyStimulus($urandom_range(0, 3) < wBias, $urandom, $urandom_range(0, 3) < rBias, acc);
    end
    for (int i = 0; i < 20; i++) applyStimulus(1'b0, '0, 1'b1, acc);
    checkOutput("random_drain_empty", sb.size(), 0);
    checkOutput("random_drain_count", count_o, 0);

    // Reset while holding data
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 32'h1000 + DW'(i), 1'b0, acc);
    applyStimulus(1'b0, '0, 1'b0, acc);
    checkOutput("prereset_count", count_o, 3);
    doReset(1);
    applyStimulus(1'b0, '0, 1'b0, acc);
    checkOutput("midreset_count", count_o, 0);
    checkOutput("midreset_rd_valid", rd_valid_o, 0);
    applyStimulus(1'b1, 32'h55, 1'b1, acc);
    applyStimulus(1'b0, '0, 1'b1, acc);
    applyStimulus(1'b0, '0, 1'b1, acc);
    checkOutput("postreset_rd_valid_n2", rd_valid_o, 0);
    applyStimulus(1'b0, '0, 1'b1, acc);
    checkOutput("postreset_rd_valid_n3", rd_valid_o, 1);
    checkOutput("postreset_rd_data_n3", rd_data_o, 32'h55);
    applyStimulus(1'b0, '0, 1'b0, acc);
    checkOutput("postreset_model_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
